mux_nx1_arb: RTL

//  - Parametrised N:1 data multiplexer. Registered output, per-channel valid/ready handshake.
//  - Two modes: explicit select (successor of the fixed 3x1 mux) and round-robin arbitration.
//  - Used wherever several producers share one downstream consumer. Supports any N >= 2, including non-power-of-two (e.g. N=3).

---
 rtl/mux_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/mux_nx1_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the N:1 multiplexer/arbiter block.
//   - sel_width(n): width of a channel index, safe for n = 1.
//   - MUX_MODE_SEL / MUX_MODE_RR: values for the MODE parameter.
//   - mux_state_e: output-register occupancy (EMPTY / FULL).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mux_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin search. Starting one position above ptr and
//   wrapping modulo N, the first requesting channel wins.
// Ports
//   req        in   N      per-channel request
//   ptr        in   SEL_W  index of the most recently granted channel
//   gnt_valid  out  1      some channel was selected
//   gnt_idx    out  SEL_W  selected channel (0 when gnt_valid = 0)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before any conditional assignment, so
    // no path leaves a value unassigned and no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // Offsets 1..N visit every channel exactly once; offset N is ptr itself,
    // so the last winner only wins again when nobody else is requesting.
    for (int off = 1; off <= N; off++) begin
      idx = int'(ptr) + off;
      // ptr never exceeds N-1, so a single subtraction is a full modulo.
      if (idx >= N) idx -= N;
      if (!gnt_valid && req[idx[SEL_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_nx1_arb.sv
// -----------------------------------------------------------------------------
// mux_nx1_arb
//   N:1 data multiplexer with a registered output stage and valid/ready
//   handshakes on every channel. MODE selects the channel either from the
//   sel input (MUX_MODE_SEL) or by round-robin among valid channels
//   (MUX_MODE_RR).
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_data    in   N*W    channel i at [i*W +: W]
//   in_valid   in   N      per-channel valid
//   in_ready   out  N      per-channel ready (zero- or one-hot, combinational)
//   sel        in   SEL_W  channel select, used in MUX_MODE_SEL only
//   out_data   out  W      registered data
//   out_valid  out  1      registered valid
//   out_ready  in   1      downstream ready
//   out_chan   out  SEL_W  registered source channel of out_data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mux_nx1_arb
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int MODE  = MUX_MODE_SEL,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_chan
);

  mux_state_e       state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;

  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             xfer;
  logic [W-1:0]     chan_data [N];

  always_comb begin
    for (int i = 0; i < N; i++) chan_data[i] = in_data[i*W +: W];
  end

  // The register can accept new data when it is empty or being drained now.
  assign load_en = (state_q == ST_EMPTY) || out_ready;
  // A grant always targets a valid channel, so grant plus room is a transfer.
  // rst_n gating keeps every in_ready low while reset is asserted.
  assign xfer    = rst_n && load_en && gnt_valid;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
      logic             unused_sel;

      assign unused_sel = ^sel;

      rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
      );

      // The pointer only moves on a completed transfer; stalls keep priority.
      always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = gnt_idx;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= SEL_W'(N - 1);
        else        rr_ptr_q <= rr_ptr_d;
      end
    end else begin : g_sel
      localparam int PAD = 1 << SEL_W;
      logic [PAD-1:0] valid_pad;

      // Zero-padding up to 2**SEL_W makes any out-of-range sel see an
      // invalid channel, so it never produces a grant.
      assign valid_pad = PAD'(in_valid);
      assign gnt_valid = valid_pad[sel];
      assign gnt_idx   = sel;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < N; i++) in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    // Data is only captured on a transfer; otherwise it holds, including
    // while EMPTY.
    if (xfer) begin
      data_d = chan_data[gnt_idx];
      chan_d = gnt_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule
